sim_dsp_simd_acc: RTL

Dual-lane result accumulator placed directly downstream of the two registered 10x9 SIMD DSP lanes. It takes the 19-bit unsigned products `z0`/`z1` on every valid beat and accumulates them over a packet delimited by `z_last_i`. It then hands the per-lane sums, or a combined dot-product sum, to the consumer over a valid/ready interface. The DSP lanes cannot stall, so the block buffers up to two finished results and flags any result it has to drop.

---
 rtl/sim_dsp_simd_acc.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sim_dsp_simd_acc.sv
// Dual-lane packet accumulator for the SIMD DSP products, with a 2-entry result FIFO.
// Results that arrive while the FIFO is full are discarded and flagged on drop_o.
module sim_dsp_simd_acc #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [18:0]          z0_i,
  input  logic [18:0]          z1_i,
  input  logic                 z_valid_i,
  input  logic                 z_last_i,
  input  logic                 mode_i,
  output logic [ACC_WIDTH-1:0] sum0_o,
  output logic [ACC_WIDTH-1:0] sum1_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 sat_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i,
  output logic                 drop_o
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] sum0;
    logic [ACC_WIDTH-1:0] sum1;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;
  } res_t;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 mode_q, mode_d;

  logic                 first;
  logic                 mode_eff;
  logic [19:0]          pair;
  logic [ACC_WIDTH-1:0] add0, add1, base0, base1, nxt0, nxt1;
  logic [ACC_WIDTH:0]   wide0, wide1;
  logic [CNT_WIDTH-1:0] nxt_cnt;
  logic                 nxt_sat;
  logic                 push;
  res_t                 new_res;

  // The first beat of a packet starts from zero rather than stale accumulator contents.
  always_comb begin
    first    = (state_q == StIdle);
    mode_eff = first ? mode_i : mode_q;
    pair     = {1'b0, z0_i} + {1'b0, z1_i};
    add0     = mode_eff ? ACC_WIDTH'(pair) : ACC_WIDTH'(z0_i);
    add1     = mode_eff ? '0 : ACC_WIDTH'(z1_i);
    base0    = first ? '0 : acc0_q;
    base1    = first ? '0 : acc1_q;
    wide0    = {1'b0, base0} + {1'b0, add0};
    wide1    = {1'b0, base1} + {1'b0, add1};
    nxt0     = wide0[ACC_WIDTH] ? '1 : wide0[ACC_WIDTH-1:0];
    nxt1     = wide1[ACC_WIDTH] ? '1 : wide1[ACC_WIDTH-1:0];
    nxt_sat  = (!first && sat_q) || wide0[ACC_WIDTH] || wide1[ACC_WIDTH];
    if (first) begin
      nxt_cnt = CNT_WIDTH'(1);
    end else if (&cnt_q) begin
      nxt_cnt = cnt_q;
    end else begin
      nxt_cnt = cnt_q + CNT_WIDTH'(1);
    end

    state_d = state_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    mode_d  = mode_q;
    if (z_valid_i) begin
      acc0_d  = nxt0;
      acc1_d  = nxt1;
      cnt_d   = nxt_cnt;
      sat_d   = nxt_sat;
      mode_d  = mode_eff;
      state_d = z_last_i ? StIdle : StAccum;
    end

    push         = z_valid_i && z_last_i;
    new_res.sum0 = nxt0;
    new_res.sum1 = nxt1;
    new_res.cnt  = nxt_cnt;
    new_res.sat  = nxt_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      mode_q  <= mode_d;
    end
  end

  // Output FIFO: ent0 is the head and drives the outputs directly.
  res_t       ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic       drop_q, drop_d;
  logic       pop;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    drop_d  = drop_q;
    pop     = (count_q != 2'd0) && sum_ready_i;
    if (push && pop) begin
      if (count_q == 2'd2) begin
        ent0_d = ent1_q;
        ent1_d = new_res;
      end else begin
        ent0_d = new_res;
      end
    end else if (pop) begin
      if (count_q == 2'd2) begin
        ent0_d = ent1_q;
      end
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        ent0_d  = new_res;
        count_d = 2'd1;
      end else if (count_q == 2'd1) begin
        ent1_d  = new_res;
        count_d = 2'd2;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign sum0_o      = ent0_q.sum0;
  assign sum1_o      = ent0_q.sum1;
  assign cnt_o       = ent0_q.cnt;
  assign sat_o       = ent0_q.sat;
  assign sum_valid_o = (count_q != 2'd0);
  assign drop_o      = drop_q;

endmodule
